// File: rtl/config_chain_loader_pkg.sv
// Shared types and constants for the per-tile configuration loader.
// Tile multiplexer selectors are SELECTOR_WIDTH bits each.
package kfpga_config_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_DONE
    } state_t;

    localparam int SELECTOR_WIDTH = 5;

    // Width needed to count from 0 up to and including the chain length.
    function automatic int counterWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Serial configuration bitstream handshake: the source drives start/valid/data,
// and the loader answers with ready.
interface config_chain_loader_if;

    logic config_start;
    logic config_valid;
    logic config_ready;
    logic config_data;

    modport master (
        output config_start,
        output config_valid,
        output config_data,
        input  config_ready
    );

    modport slave (
        input  config_start,
        input  config_valid,
        input  config_data,
        output config_ready
    );

endinterface

// File: rtl/config_chain_loader_shift.sv
// Shadow shift chain: shifts one bit in at the LSB per enable and registers the
// displaced MSB onto the daisy-chain output with a one-cycle strobe.
module config_shift_register #(
    parameter int WIDTH = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_shift,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_shadow,
    output logic             o_chain_out,
    output logic             o_chain_out_valid
);

    logic [WIDTH-1:0] r_shadow;
    logic             r_chainOut;
    logic             r_chainOutValid;

    // Clear wins over shift; the caller already suppresses shifting on clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow        <= '0;
            r_chainOut      <= 1'b0;
            r_chainOutValid <= 1'b0;
        end else begin
            r_chainOutValid <= i_shift && !i_clear;
            if (i_clear) begin
                r_shadow <= '0;
            end else if (i_shift) begin
                r_shadow   <= {r_shadow[WIDTH-2:0], i_data};
                r_chainOut <= r_shadow[WIDTH-1];
            end
        end
    end

    assign o_shadow          = r_shadow;
    assign o_chain_out       = r_chainOut;
    assign o_chain_out_valid = r_chainOutValid;

endmodule

// File: rtl/config_chain_loader.sv
// Per-tile configuration loader: accepts a serial bitstream into a shadow chain
// and atomically commits the full chain to the parallel configuration bus.
module config_chain_loader
    import kfpga_config_pkg::*;
#(
    parameter int CONFIG_WIDTH = 8 * SELECTOR_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    config_chain_loader_if.slave    busIf,
    output logic                    chain_out,
    output logic                    chain_out_valid,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_done
);

    localparam int CW = counterWidth(CONFIG_WIDTH);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CW-1:0]           r_count;
    logic [CONFIG_WIDTH-1:0] r_configOut;
    logic                    r_configDone;
    logic [CONFIG_WIDTH-1:0] w_shadow;
    logic                    w_ready;
    logic                    w_accept;
    logic                    w_clear;
    logic                    w_lastBit;

    // A start in SHIFT discards a simultaneous transfer; a start from DONE keeps
    // the shadow so the old configuration is pushed down the daisy chain.
    assign w_accept  = busIf.config_valid && (r_state == ST_SHIFT) && !busIf.config_start;
    assign w_clear   = busIf.config_start && ((r_state == ST_IDLE) || (r_state == ST_SHIFT));
    assign w_lastBit = w_accept && (r_count == CW'(CONFIG_WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (busIf.config_start) begin
                    w_nextState = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_ready = 1'b1;
                if (w_lastBit) begin
                    w_nextState = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_nextState = ST_DONE;
            end
            ST_DONE: begin
                if (busIf.config_start) begin
                    w_nextState = ST_SHIFT;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (busIf.config_start && (r_state != ST_COMMIT)) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_configOut  <= '0;
            r_configDone <= 1'b0;
        end else if (r_state == ST_COMMIT) begin
            r_configOut  <= w_shadow;
            r_configDone <= 1'b1;
        end else if ((r_state == ST_DONE) && busIf.config_start) begin
            r_configDone <= 1'b0;
        end
    end

    config_shift_register #(
        .WIDTH(CONFIG_WIDTH)
    ) u_shift (
        .clock            (clock),
        .reset            (reset),
        .i_clear          (w_clear),
        .i_shift          (w_accept),
        .i_data           (busIf.config_data),
        .o_shadow         (w_shadow),
        .o_chain_out      (chain_out),
        .o_chain_out_valid(chain_out_valid)
    );

    assign busIf.config_ready = w_ready;
    assign config_out         = r_configOut;
    assign config_done        = r_configDone;

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench for config_chain_loader: a queue-based chain model predicts
// displaced daisy-chain bits and committed words; a monitor checks them.
module tb_config_chain_loader;

    localparam int W = 40;

    logic         clock = 1'b0;
    logic         reset;
    logic         chainOut;
    logic         chainOutValid;
    logic         configDone;
    logic [W-1:0] configOut;

    config_chain_loader_if busIf();

    config_chain_loader #(
        .CONFIG_WIDTH(W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .busIf          (busIf),
        .chain_out      (chainOut),
        .chain_out_valid(chainOutValid),
        .config_out     (configOut),
        .config_done    (configDone)
    );

    always #5 clock = ~clock;

    int           errors = 0;
    int           checks = 0;
    bit           modelShadow[$];
    bit           expChain[$];
    logic [W-1:0] expCommit[$];
    int           modelCount = 0;
    bit           modelInDone = 0;
    int           transferCount = 0;
    logic [W-1:0] driverCommitted = '0;
    logic [W-1:0] monCommitted = '0;
    bit           monitorOn = 0;
    bit           prevDone = 0;
    int           chainPulses = 0;
    int           chainOnes = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model of the shadow chain: index 0 is the oldest bit (the chain MSB).
    function automatic logic [W-1:0] packShadow();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
            v[W-1-i] = modelShadow[i];
        end
        return v;
    endfunction

    task automatic modelClear();
        modelShadow.delete();
        repeat (W) modelShadow.push_back(1'b0);
    endtask

    task automatic modelAccept(input bit b);
        expChain.push_back(modelShadow.pop_front());
        modelShadow.push_back(b);
        modelCount++;
        transferCount++;
        if (modelCount == W) begin
            expCommit.push_back(packShadow());
            modelInDone = 1;
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        bit           b;
        logic [W-1:0] exp;
        forever begin
            @(negedge clock);
            if (monitorOn) begin
                if (chainOutValid) begin
                    chainPulses++;
                    if (chainOut) chainOnes++;
                    if (expChain.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_chain_out: got strobe with bit %0b, expected none", chainOut);
                    end else begin
                        b = expChain.pop_front();
                        checkOutput("chain_out_bit", 64'(chainOut), 64'(b));
                    end
                end
                if (reset) begin
                    monCommitted = '0;
                end else if (configDone && !prevDone) begin
                    if (expCommit.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_commit: got config_out 0x%0h, expected no commit", configOut);
                    end else begin
                        exp = expCommit.pop_front();
                        checkOutput("committed_config_out", 64'(configOut), 64'(exp));
                        monCommitted = exp;
                    end
                end else begin
                    checkOutput("config_out_held", 64'(configOut), 64'(monCommitted));
                end
                prevDone = configDone;
            end
        end
    end

    task automatic doStart();
        @(negedge clock);
        busIf.config_start = 1'b1;
        busIf.config_valid = 1'b0;
        if (!modelInDone) modelClear();
        modelCount  = 0;
        modelInDone = 0;
        @(negedge clock);
        busIf.config_start = 1'b0;
        checkOutput("ready_after_start", 64'(busIf.config_ready), 64'd1);
        checkOutput("done_cleared_on_start", 64'(configDone), 64'd0);
    endtask

    // Sends nbits of value MSB-first; validPct is the chance per cycle of presenting a bit.
    task automatic applyStimulus(input logic [63:0] value, input int nbits, input int validPct);
        bit useValid;
        for (int i = nbits - 1; i >= 0; i--) begin
            do begin
                @(negedge clock);
                useValid = ($urandom_range(99) < validPct);
                busIf.config_valid = useValid;
                busIf.config_data  = useValid ? value[i] : 1'($urandom_range(1));
            end while (!useValid);
            checkOutput("ready_in_shift", 64'(busIf.config_ready), 64'd1);
            if (busIf.config_ready) modelAccept(value[i]);
        end
    endtask

    task automatic finishLoad(input logic [W-1:0] expVal);
        @(negedge clock);
        busIf.config_valid = 1'b1;
        busIf.config_data  = 1'b1;
        checkOutput("ready_low_after_last", 64'(busIf.config_ready), 64'd0);
        checkOutput("done_before_commit", 64'(configDone), 64'd0);
        checkOutput("out_held_until_commit", 64'(configOut), 64'(driverCommitted));
        @(negedge clock);
        checkOutput("done_after_commit", 64'(configDone), 64'd1);
        checkOutput("out_after_commit", 64'(configOut), 64'(expVal));
        checkOutput("ready_low_in_done", 64'(busIf.config_ready), 64'd0);
        repeat (2) begin
            @(negedge clock);
            checkOutput("no_extra_accept", 64'(busIf.config_ready), 64'd0);
        end
        busIf.config_valid = 1'b0;
        driverCommitted = expVal;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        busIf.config_start = 1'b0;
        busIf.config_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        modelClear();
        modelCount      = 0;
        modelInDone     = 0;
        driverCommitted = '0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] randVal;
        reset = 1'b1;
        busIf.config_start = 1'b0;
        busIf.config_valid = 1'b0;
        busIf.config_data  = 1'b0;
        modelClear();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        monitorOn = 1;

        $display("[TB] reset and idle");
        repeat (5) @(negedge clock);
        checkOutput("idle_ready", 64'(busIf.config_ready), 64'd0);
        checkOutput("idle_config_out", 64'(configOut), 64'd0);
        checkOutput("idle_done", 64'(configDone), 64'd0);
        checkOutput("idle_chain_valid", 64'(chainOutValid), 64'd0);

        $display("[TB] full load, valid held high");
        doStart();
        applyStimulus(64'hA53CF00F81, W, 100);
        finishLoad(40'hA53CF00F81);

        $display("[TB] full load, valid randomly gapped");
        doStart();
        transferCount = 0;
        applyStimulus(64'hA53CF00F81, W, 50);
        finishLoad(40'hA53CF00F81);
        checkOutput("transfer_count", 64'(transferCount), 64'd40);

        $display("[TB] all ones then all zeros through the daisy chain");
        doStart();
        applyStimulus(64'hFFFFFFFFFF, W, 75);
        finishLoad({W{1'b1}});
        chainPulses = 0;
        chainOnes   = 0;
        doStart();
        applyStimulus(64'h0, W, 75);
        finishLoad('0);
        checkOutput("chain_pulses", 64'(chainPulses), 64'd40);
        checkOutput("chain_ones", 64'(chainOnes), 64'd40);

        $display("[TB] restart after 17 bits");
        doStart();
        applyStimulus(64'({$urandom(), $urandom()}), 17, 70);
        doStart();
        applyStimulus(64'h0123456789, W, 80);
        finishLoad(40'h0123456789);

        $display("[TB] reset after 25 bits");
        doStart();
        applyStimulus(64'({$urandom(), $urandom()}), 25, 60);
        doReset();
        @(negedge clock);
        checkOutput("reset_config_out", 64'(configOut), 64'd0);
        checkOutput("reset_ready", 64'(busIf.config_ready), 64'd0);
        checkOutput("reset_done", 64'(configDone), 64'd0);
        checkOutput("reset_chain_valid", 64'(chainOutValid), 64'd0);
        randVal = W'({$urandom(), $urandom()});
        doStart();
        applyStimulus(64'(randVal), W, 65);
        finishLoad(randVal);

        $display("[TB] random back-to-back loads");
        for (int n = 0; n < 3; n++) begin
            randVal = W'({$urandom(), $urandom()});
            doStart();
            applyStimulus(64'(randVal), W, $urandom_range(30, 100));
            finishLoad(randVal);
        end

        repeat (3) @(negedge clock);
        checkOutput("chain_queue_drained", 64'(expChain.size()), 64'd0);
        checkOutput("commit_queue_drained", 64'(expCommit.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Per-tile configuration loader that receives the serial bitstream over a valid/ready handshake and shifts it into a shadow chain. On the final bit it atomically commits the whole chain to the parallel `config_out` bus. That bus drives the 5-bit selector inputs of the tile's switch-box-to-LE multiplexers and the other configurable elements. Because the commit is atomic, the multiplexers never see a partially shifted selector. Bits displaced from the chain are forwarded on a daisy-chain output to the next tile.

## Interface
Parameters:
- `CONFIG_WIDTH`, default 40: total configuration bits held by the tile (8 multiplexers × 5 selector bits); legal range ≥ 2.

Ports:
- `clock`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `config_start`  in  1  single-cycle pulse that begins (or restarts) a load.
- `config_valid`  in  1  `config_data` holds a valid bit.
- `config_ready`  out  1  loader accepts a bit this cycle.
- `config_data`  in  1  serial configuration bit.
- `chain_out`  out  1  bit displaced from the shadow MSB (daisy chain).
- `chain_out_valid`  out  1  single-cycle strobe qualifying `chain_out`.
- `config_out`  out  CONFIG_WIDTH  committed configuration.
- `config_done`  out  1  high while a complete configuration is committed.

## Operation
- A transfer occurs on a rising edge where `config_valid && config_ready`.
- Shift rule: `shadow <= {shadow[CONFIG_WIDTH-2:0], config_data}`.
  - After a full load, the first bit received sits in `config_out[CONFIG_WIDTH-1]` and the last in `config_out[0]`.
- The displaced `shadow[CONFIG_WIDTH-1]` is registered into `chain_out`. `chain_out_valid` is 1 for exactly the cycle after each transfer.
- The bit counter counts accepted bits. Its width is `$clog2(CONFIG_WIDTH+1)`. It never exceeds `CONFIG_WIDTH`.
- FSM states and transitions:
  - IDLE: `config_ready`=0. `config_start` → SHIFT, with counter cleared and shadow cleared.
  - SHIFT: `config_ready`=1. Each transfer increments the counter. The transfer that brings the count to `CONFIG_WIDTH` → COMMIT.
  - COMMIT: `config_ready`=0. `config_out <= shadow` and `config_done <= 1`, then → DONE.
  - DONE: `config_ready`=0. `config_start` → SHIFT, with `config_done <= 0` and counter cleared.
- `config_start` in SHIFT restarts the load: counter cleared, shadow cleared, stays in SHIFT. A transfer in that same cycle is discarded.
- `config_start` in COMMIT is ignored; the commit completes.
- `config_out` holds its value through IDLE, SHIFT and DONE. It changes only in COMMIT or reset.
- `config_valid` while `config_ready`=0 is not a transfer. The source holds the data.

## Timing
- Reset values: state IDLE, `config_ready`=0, `config_out`=0 (every multiplexer selects input 0), `config_done`=0, `chain_out`=0, `chain_out_valid`=0, shadow=0, counter=0.
- Reset asserted mid-load aborts the load. All of the values above apply after that edge, and `config_out` is cleared.
- `config_ready` is decoded from registered state only; no combinational path from any input.
- `config_start` at edge S: `config_ready`=1 from cycle S+1.
- Last transfer at edge E: `config_ready`=0 after E. `config_out` and `config_done` update at edge E+1.
- Peak throughput is one bit per cycle. A full load takes `CONFIG_WIDTH`+1 cycles from the first transfer to `config_done`.

## Structure
- Shared package `kfpga_config_pkg`:
  - state enum (IDLE, SHIFT, COMMIT, DONE);
  - the selector width constant (5);
  - the counter-width function.
- Sub-module `config_shift_register`: the shadow register, shift-on-enable, clear, and the registered `chain_out`/`chain_out_valid` outputs.
- The FSM, counter and commit register live in the top module.

## Test plan
- Reset, then idle 5 cycles → `config_ready`=0, `config_out`=0, `config_done`=0, `chain_out_valid`=0.
- `CONFIG_WIDTH`=40: start, stream 40 bits of 0xA5_3C_F0_0F_81 MSB-first with valid held high → `config_out`=0xA53CF00F81 one cycle after the 40th transfer. `config_done`=1, `config_ready`=0, no extra bits accepted.
- Same stream with valid randomly deasserted ~50% → identical `config_out`. Total transfers = 40.
- Load 0xFF..FF, then a second load of 40 zeros → `chain_out_valid` pulses 40 times, all `chain_out`=1. Final `config_out`=0. Old value held until the commit edge.
- `config_start` after 17 bits, then a full 40-bit load of 0x0123456789 → `config_out`=0x0123456789. The 17 partial bits have no effect.
- Reset asserted after 25 bits of a load → `config_out`=0, state IDLE. A subsequent start and full load commits correctly.
